bcd_conv_sched: RTL and testbench

// - Sequences one shared BCD-to-binary converter (registered, 8-bit packed BCD in, binary out) over NFIELDS time fields (sec,min,hour,day,month,year).
// - Sits between the RTC read-back registers and the display/alarm logic.
// - On a start pulse it snapshots all BCD fields and feeds them to the converter one at a time.
// - It captures each result and publishes all binary fields atomically, with per-field BCD error flags.

---
 rtl/bcd_conv_sched.sv | 162 ++++++++++++++++
 tb/tb_bcd_conv_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: time-shares one registered BCD-to-binary converter across
// NFIELDS packed BCD time fields. A sweep snapshots every field, issues each
// one to the converter, captures the results and publishes all binary fields
// and per-field BCD error flags together with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      request one sweep (honoured only while idle)
//   fields_bcd packed BCD fields, field 0 = bits [7:0]
//   conv_bcd   registered operand to the shared converter
//   conv_bin   converter result, valid CONV_LAT cycles after conv_bcd
//   fields_bin published binary fields, updated only with done
//   err        per-field flag: a nibble above 9 in the last sweep
//   busy       sweep in progress
//   done       one-cycle pulse, fields_bin/err just updated
//
// Optional feature: define BCD_SCHED_AUTO_EN to add a free-running refresh
// counter (period REFRESH_DIV) that launches sweeps without a start pulse.
module bcd_conv_sched #(
  parameter int unsigned NFIELDS     = 6,
  parameter int unsigned CONV_LAT    = 1,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*NFIELDS-1:0]   fields_bcd,
  output logic [7:0]             conv_bcd,
  input  logic [7:0]             conv_bin,
  output logic [8*NFIELDS-1:0]   fields_bin,
  output logic [NFIELDS-1:0]     err,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IDX_W    = (NFIELDS > 1) ? $clog2(NFIELDS) : 1;
  localparam int unsigned WAIT_W   = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
  localparam int unsigned LAST_IDX = NFIELDS - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [WAIT_W-1:0]         wait_cnt;
  logic [NFIELDS-1:0][7:0]   snap;
  logic [NFIELDS-1:0][7:0]   stage;
  logic [NFIELDS-1:0]        err_stage;
  logic [NFIELDS-1:0][7:0]   stage_mrg;
  logic [NFIELDS-1:0]        err_mrg;
  logic                      launch;

`ifdef BCD_SCHED_AUTO_EN
  // Refresh counter: each wrap raises pending; repeated wraps collapse into one.
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [REF_W-1:0] ref_cnt;
  logic             pending;
  logic             wrap;

  assign wrap   = (ref_cnt == REF_W'(REFRESH_DIV - 1));
  assign launch = (state == S_IDLE) && (start || pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      pending <= 1'b0;
    end else begin
      ref_cnt <= wrap ? '0 : ref_cnt + REF_W'(1);
      // A wrap coinciding with a launch re-arms for the next sweep.
      if (wrap)
        pending <= 1'b1;
      else if (launch)
        pending <= 1'b0;
    end
  end
`else
  assign launch = (state == S_IDLE) && start;

  // REFRESH_DIV only matters with the auto-refresh build; this elaborates empty.
  if (REFRESH_DIV == 0) begin : g_refresh_div_unused
  end
`endif

  // Current field's result folded into the staging copy, so the last
  // capture can publish in the same edge that raises done.
  always_comb begin
    stage_mrg      = stage;
    err_mrg        = err_stage;
    stage_mrg[idx] = conv_bin;
    err_mrg[idx]   = (snap[idx][7:4] > 4'd9) | (snap[idx][3:0] > 4'd9);
  end

  // Sweep sequencer: IDLE -> (ISSUE -> WAIT x CONV_LAT -> CAPTURE) x NFIELDS -> DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      snap       <= '0;
      stage      <= '0;
      err_stage  <= '0;
      conv_bcd   <= '0;
      fields_bin <= '0;
      err        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            snap     <= fields_bcd;
            idx      <= '0;
            conv_bcd <= fields_bcd[7:0];
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_W'(CONV_LAT - 1))
            state <= S_CAPTURE;
          else
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        S_CAPTURE: begin
          stage     <= stage_mrg;
          err_stage <= err_mrg;
          if (idx == IDX_W'(LAST_IDX)) begin
            fields_bin <= stage_mrg;
            err        <= err_mrg;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else begin
            // Operand changes only here, so it is stable from ISSUE through CAPTURE.
            idx      <= idx + IDX_W'(1);
            conv_bcd <= snap[idx + IDX_W'(1)];
            state    <= S_ISSUE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Randomized self-checking bench for bcd_conv_sched. Two instances (converter
// latency 1 and 3) share the stimulus; a transaction-level model tracks where
// each sweep should be and what it should publish.
module tb_bcd_conv_sched;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [47:0]   fields_bcd;

  logic [7:0]    conv_bcd_a, conv_bin_a, conv_bcd_b, conv_bin_b;
  logic [47:0]   fields_bin_a, fields_bin_b;
  logic [5:0]    err_a, err_b;
  logic          busy_a, done_a, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_conv_sched #(.NFIELDS(N), .CONV_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .fields_bcd(fields_bcd),
    .conv_bcd(conv_bcd_a), .conv_bin(conv_bin_a), .fields_bin(fields_bin_a),
    .err(err_a), .busy(busy_a), .done(done_a)
  );

  bcd_conv_sched #(.NFIELDS(N), .CONV_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .fields_bcd(fields_bcd),
    .conv_bcd(conv_bcd_b), .conv_bin(conv_bin_b), .fields_bin(fields_bin_b),
    .err(err_b), .busy(busy_b), .done(done_b)
  );

  // Converter models: invalid BCD converts to 0.
  function automatic logic [7:0] conv_fn(input logic [7:0] b);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return 8'd0;
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  logic [7:0] pipe_b [3];

  always_ff @(posedge clk) begin
    if (reset) begin
      conv_bin_a <= '0;
      pipe_b[0]  <= '0;
      pipe_b[1]  <= '0;
      pipe_b[2]  <= '0;
    end else begin
      conv_bin_a <= conv_fn(conv_bcd_a);
      pipe_b[0]  <= conv_fn(conv_bcd_b);
      pipe_b[1]  <= pipe_b[0];
      pipe_b[2]  <= pipe_b[1];
    end
  end
  assign conv_bin_b = pipe_b[2];

  // Reference: expected publish values by decimal arithmetic on each field.
  function automatic logic [47:0] ref_bin(input logic [47:0] f);
    logic [47:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int v  = int'(f[8*i +: 8]);
      int hi = v / 16;
      int lo = v % 16;
      if (hi <= 9 && lo <= 9) r[8*i +: 8] = 8'(hi * 10 + lo);
    end
    return r;
  endfunction

  function automatic logic [5:0] ref_err(input logic [47:0] f);
    logic [5:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int v = int'(f[8*i +: 8]);
      r[i] = (v / 16 > 9) || (v % 16 > 9);
    end
    return r;
  endfunction

  // Model state per instance: pos = cycles since the accepting edge (0 = idle).
  int          lat [2] = '{1, 3};
  int          pos [2];
  logic [47:0] snap [2];
  logic [47:0] pub_bin [2];
  logic [5:0]  pub_err [2];
  logic [7:0]  exp_conv [2];

  function automatic int sweep_len(input int k);
    return N * (2 + lat[k]) + 1;
  endfunction

  task automatic model_step(input int k, input logic r, input logic s, input logic [47:0] f);
    int sw = sweep_len(k);
    if (r) begin
      pos[k] = 0; pub_bin[k] = '0; pub_err[k] = '0; exp_conv[k] = '0; snap[k] = '0;
    end else if (pos[k] > 0) begin
      pos[k]++;
      if (pos[k] > sw) pos[k] = 0;
      else if (pos[k] < sw) exp_conv[k] = snap[k][8*((pos[k]-1)/(2+lat[k])) +: 8];
      else begin
        pub_bin[k] = ref_bin(snap[k]);
        pub_err[k] = ref_err(snap[k]);
      end
    end else if (s) begin
      pos[k] = 1; snap[k] = f; exp_conv[k] = f[7:0];
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic bsy, input logic dn, input logic [7:0] cb,
                            input logic [47:0] fb, input logic [5:0] e);
    int sw = sweep_len(k);
    check($sformatf("i%0d_busy", k), 64'(bsy), 64'(pos[k] >= 1 && pos[k] < sw));
    check($sformatf("i%0d_done", k), 64'(dn), 64'(pos[k] == sw));
    check($sformatf("i%0d_conv_bcd", k), 64'(cb), 64'(exp_conv[k]));
    check($sformatf("i%0d_fields_bin", k), 64'(fb), 64'(pub_bin[k]));
    check($sformatf("i%0d_err", k), 64'(e), 64'(pub_err[k]));
  endtask

  task automatic cycle(input logic r, input logic s, input logic [47:0] f);
    reset = r; start = s; fields_bcd = f;
    @(posedge clk);
    model_step(0, r, s, f);
    model_step(1, r, s, f);
    #1;
    check_inst(0, busy_a, done_a, conv_bcd_a, fields_bin_a, err_a);
    check_inst(1, busy_b, done_b, conv_bcd_b, fields_bin_b, err_b);
  endtask

  function automatic logic [47:0] rand_fields();
    logic [47:0] f;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 11) == 0) f[8*i +: 8] = 8'($urandom);
      else f[8*i +: 8] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    end
    return f;
  endfunction

  localparam logic [47:0] T1 = 48'h23_12_31_23_59_45;
  localparam logic [47:0] T2 = 48'h23_12_31_3A_59_45;

  initial begin
    reset = 1'b1; start = 1'b0; fields_bcd = '0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);

    // Plain sweep; instance a publishes at cycle 19, instance b at 31.
    cycle(1'b0, 1'b1, T1);
    for (int i = 1; i < 19; i++) cycle(1'b0, 1'b0, T1);
    check("t1_done_at_19", 64'(done_a), 64'd1);
    check("t1_bin_dec", 64'(fields_bin_a), 64'({8'd23, 8'd12, 8'd31, 8'd23, 8'd59, 8'd45}));
    for (int i = 19; i < 35; i++) cycle(1'b0, 1'b0, T1);

    // Invalid field 2.
    cycle(1'b0, 1'b1, T2);
    for (int i = 1; i < 35; i++) cycle(1'b0, 1'b0, T2);
    check("t2_err", 64'(err_a), 64'(6'b000100));

    // Input change and extra start mid-sweep are ignored.
    cycle(1'b0, 1'b1, T1);
    for (int i = 1; i < 35; i++)
      cycle(1'b0, i == 5, (i >= 3) ? 48'h99_99_99_99_99_99 : T1);

    // Reset mid-sweep, then a fresh sweep.
    cycle(1'b0, 1'b1, T2);
    for (int i = 1; i < 7; i++) cycle(1'b0, 1'b0, T2);
    cycle(1'b1, 1'b0, T2);
    check("t4_bin_cleared", 64'(fields_bin_a), 64'd0);
    cycle(1'b0, 1'b0, T1);
    cycle(1'b0, 1'b1, T1);
    for (int i = 1; i < 35; i++) cycle(1'b0, 1'b0, T1);

    // Start held through a whole sweep: re-accepted only after DONE.
    for (int i = 0; i < 45; i++) cycle(1'b0, 1'b1, T2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 7) == 0, rand_fields());
    for (int i = 0; i < 35; i++) cycle(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
